// File: rtl/rf_slew_irq_gen.sv
// Per-channel RF slew-fault qualifier: debounces raw slew flags through a
// qualify/hold-off FSM and raises a maskable sticky interrupt plus a saturating event count.
module rf_slew_irq_gen #(
   parameter int N_CH     = 8,
   parameter int QUAL_CYC = 4,
   parameter int HOLD_CYC = 16,
   parameter int CNT_W    = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_CH-1:0]             slew_fault_raw,
   input  logic [N_CH-1:0]             mon_en,
   input  logic [N_CH-1:0]             rf_slew_rate_irq_mask,
   input  logic [N_CH-1:0]             rf_slew_rate_irq_clr,
   input  logic [N_CH-1:0]             rf_slew_fault_clr,
   output logic [N_CH-1:0]             rf_slew_rate_irq,
   output logic                        rf_slew_irq_any,
   output logic [N_CH-1:0][CNT_W-1:0]  rf_slew_fault_count,
   output logic [N_CH-1:0]             rf_slew_active
);

   localparam int QMAX = (QUAL_CYC > HOLD_CYC) ? QUAL_CYC : HOLD_CYC;
   localparam int QW   = $clog2(QMAX + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUAL    = 2'd1,
      ACTIVE  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   logic [N_CH-1:0] status_vec_s;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_t           state_r;
      logic [QW-1:0]    qcnt_r;
      logic             active_r;
      logic             status_r;
      logic [CNT_W-1:0] count_r;
      logic             event_s;
      logic             raw_s;

      assign raw_s = slew_fault_raw[g];

      // Event fires on the edge that samples the QUAL_CYC-th consecutive high.
      always_comb begin
         event_s = 1'b0;
         if (mon_en[g] && raw_s) begin
            case (state_r)
               IDLE:    event_s = (QUAL_CYC == 32'sd1);
               QUAL:    event_s = (qcnt_r == QW'(QUAL_CYC - 1));
               default: event_s = 1'b0;
            endcase
         end else begin
            event_s = 1'b0;
         end
      end

      // Qualify / hold-off state machine with registered activity flag.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_r  <= IDLE;
            qcnt_r   <= '0;
            active_r <= 1'b0;
         end else if (!mon_en[g]) begin
            state_r  <= IDLE;
            qcnt_r   <= '0;
            active_r <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (raw_s && event_s) begin
                     state_r  <= ACTIVE;
                     qcnt_r   <= '0;
                     active_r <= 1'b1;
                  end else if (raw_s) begin
                     state_r  <= QUAL;
                     qcnt_r   <= QW'(1);
                     active_r <= 1'b0;
                  end else begin
                     state_r  <= IDLE;
                     qcnt_r   <= '0;
                     active_r <= 1'b0;
                  end
               end
               QUAL: begin
                  if (!raw_s) begin
                     state_r  <= IDLE;
                     qcnt_r   <= '0;
                     active_r <= 1'b0;
                  end else if (event_s) begin
                     state_r  <= ACTIVE;
                     qcnt_r   <= '0;
                     active_r <= 1'b1;
                  end else begin
                     state_r  <= QUAL;
                     qcnt_r   <= qcnt_r + QW'(1);
                     active_r <= 1'b0;
                  end
               end
               ACTIVE: begin
                  if (!raw_s) begin
                     state_r <= RECOVER;
                     qcnt_r  <= QW'(1);
                  end else begin
                     state_r <= ACTIVE;
                     qcnt_r  <= '0;
                  end
                  active_r <= 1'b1;
               end
               RECOVER: begin
                  // A high sample here is chatter on an existing fault, not a new event.
                  if (raw_s) begin
                     state_r  <= ACTIVE;
                     qcnt_r   <= '0;
                     active_r <= 1'b1;
                  end else if (qcnt_r == QW'(HOLD_CYC)) begin
                     state_r  <= IDLE;
                     qcnt_r   <= '0;
                     active_r <= 1'b0;
                  end else begin
                     state_r  <= RECOVER;
                     qcnt_r   <= qcnt_r + QW'(1);
                     active_r <= 1'b1;
                  end
               end
               default: begin
                  state_r  <= IDLE;
                  qcnt_r   <= '0;
                  active_r <= 1'b0;
               end
            endcase
         end
      end

      // Sticky status: set has priority over clear.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            status_r <= 1'b0;
         end else if (event_s) begin
            status_r <= 1'b1;
         end else if (rf_slew_rate_irq_clr[g]) begin
            status_r <= 1'b0;
         end else begin
            status_r <= status_r;
         end
      end

      // Saturating event counter; a coincident clear and event leaves one count.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            count_r <= '0;
         end else if (rf_slew_fault_clr[g]) begin
            count_r <= {{(CNT_W-1){1'b0}}, event_s};
         end else if (event_s && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
         end else begin
            count_r <= count_r;
         end
      end

      assign status_vec_s[g]        = status_r;
      assign rf_slew_active[g]      = active_r;
      assign rf_slew_fault_count[g] = count_r;
   end

   assign rf_slew_rate_irq = status_vec_s & ~rf_slew_rate_irq_mask;
   assign rf_slew_irq_any  = |rf_slew_rate_irq;

endmodule

// File: tb/tb_rf_slew_irq_gen.sv
// Self-checking bench for rf_slew_irq_gen: directed scenarios plus randomized
// traffic compared against a run-length based reference model.
module tb_rf_slew_irq_gen;

   localparam int N_CH     = 8;
   localparam int QUAL_CYC = 4;
   localparam int HOLD_CYC = 16;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = 15;

   logic                       clk;
   logic                       rst_n;
   logic [N_CH-1:0]            raw;
   logic [N_CH-1:0]            en;
   logic [N_CH-1:0]            mask;
   logic [N_CH-1:0]            clr;
   logic [N_CH-1:0]            fclr;
   logic [N_CH-1:0]            irq;
   logic                       irq_any;
   logic [N_CH-1:0][CNT_W-1:0] count;
   logic [N_CH-1:0]            active;

   int n_checks;
   int n_fail;

   // reference model state: run lengths of highs/lows, fault flag, status, count
   int hi_run   [N_CH];
   int lo_run   [N_CH];
   bit in_fault [N_CH];
   bit stat     [N_CH];
   int cnt      [N_CH];

   rf_slew_irq_gen #(
      .N_CH(N_CH), .QUAL_CYC(QUAL_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .slew_fault_raw        (raw),
      .mon_en                (en),
      .rf_slew_rate_irq_mask (mask),
      .rf_slew_rate_irq_clr  (clr),
      .rf_slew_fault_clr     (fclr),
      .rf_slew_rate_irq      (irq),
      .rf_slew_irq_any       (irq_any),
      .rf_slew_fault_count   (count),
      .rf_slew_active        (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         hi_run[c] = 0; lo_run[c] = 0; in_fault[c] = 1'b0; stat[c] = 1'b0; cnt[c] = 0;
      end
   endtask

   task automatic model_update();
      for (int c = 0; c < N_CH; c++) begin
         bit ev;
         ev = 1'b0;
         if (!en[c]) begin
            in_fault[c] = 1'b0; hi_run[c] = 0; lo_run[c] = 0;
         end else if (!in_fault[c]) begin
            if (raw[c]) begin
               hi_run[c]++;
               if (hi_run[c] == QUAL_CYC) begin
                  ev = 1'b1; in_fault[c] = 1'b1; hi_run[c] = 0; lo_run[c] = 0;
               end
            end else begin
               hi_run[c] = 0;
            end
         end else begin
            if (raw[c]) begin
               lo_run[c] = 0;
            end else begin
               lo_run[c]++;
               if (lo_run[c] > HOLD_CYC) begin
                  in_fault[c] = 1'b0; lo_run[c] = 0; hi_run[c] = 0;
               end
            end
         end
         if (ev) stat[c] = 1'b1;
         else if (clr[c]) stat[c] = 1'b0;
         if (fclr[c]) cnt[c] = ev ? 1 : 0;
         else if (ev && cnt[c] < CNT_MAX) cnt[c]++;
      end
   endtask

   function automatic logic [N_CH-1:0] model_irq();
      logic [N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++) v[c] = stat[c] & ~mask[c];
      return v;
   endfunction

   function automatic logic [N_CH-1:0] model_active();
      logic [N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++) v[c] = in_fault[c];
      return v;
   endfunction

   // one clock edge; pulse inputs are dropped afterwards
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      #1;
      clr  = '0;
      fclr = '0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (irq !== '0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
      n_checks++; if (irq_any !== 1'b0) begin n_fail++; $display("FAIL reset_any got=%b exp=0", irq_any); end
      n_checks++; if (active !== '0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", active); end
      n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", count); end
      rst_n = 1'b1;
   endtask

   task automatic test_qualify();
      raw = 8'h01;
      repeat (3) tick();
      raw = 8'h00;
      tick();
      n_checks++; if (count[0] !== 4'd0) begin n_fail++; $display("FAIL qual3_count got=%0d exp=0", count[0]); end
      n_checks++; if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL qual3_irq got=%b exp=0", irq[0]); end
      raw = 8'h01;
      repeat (3) tick();
      n_checks++; if (active[0] !== 1'b0) begin n_fail++; $display("FAIL qual_early_active got=%b exp=0", active[0]); end
      tick();
      n_checks++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL qual4_irq got=%b exp=1", irq[0]); end
      n_checks++; if (count[0] !== 4'd1) begin n_fail++; $display("FAIL qual4_count got=%0d exp=1", count[0]); end
      n_checks++; if (active[0] !== 1'b1) begin n_fail++; $display("FAIL qual4_active got=%b exp=1", active[0]); end
   endtask

   task automatic test_holdoff();
      raw = 8'h00; repeat (10) tick();
      raw = 8'h01; tick();
      raw = 8'h00; repeat (16) tick();
      n_checks++; if (count[0] !== 4'd1) begin n_fail++; $display("FAIL hold_count got=%0d exp=1", count[0]); end
      tick();
      n_checks++; if (active[0] !== 1'b0) begin n_fail++; $display("FAIL hold_idle got=%b exp=0", active[0]); end
      raw = 8'h01; repeat (4) tick();
      n_checks++; if (count[0] !== 4'd2) begin n_fail++; $display("FAIL hold_reburst got=%0d exp=2", count[0]); end
   endtask

   task automatic test_mask_clear();
      raw = 8'h04; clr = 8'h01; mask = 8'h04;
      repeat (4) tick();
      n_checks++; if (irq !== 8'h00) begin n_fail++; $display("FAIL mask_irq got=%b exp=00000000", irq); end
      n_checks++; if (irq_any !== 1'b0) begin n_fail++; $display("FAIL mask_any got=%b exp=0", irq_any); end
      n_checks++; if (count[2] !== 4'd1) begin n_fail++; $display("FAIL mask_count got=%0d exp=1", count[2]); end
      mask = 8'h00;
      #1;
      n_checks++; if (irq[2] !== 1'b1) begin n_fail++; $display("FAIL unmask_irq got=%b exp=1", irq[2]); end
      n_checks++; if (irq_any !== 1'b1) begin n_fail++; $display("FAIL unmask_any got=%b exp=1", irq_any); end
      clr = 8'h04; tick();
      n_checks++; if (irq[2] !== 1'b0) begin n_fail++; $display("FAIL clr_irq got=%b exp=0", irq[2]); end
      raw = 8'h00; en = 8'hFB; tick();
      en = 8'hFF; raw = 8'h04; repeat (3) tick();
      clr = 8'h04; tick();
      n_checks++; if (irq[2] !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq got=%b exp=1", irq[2]); end
      n_checks++; if (count[2] !== 4'd2) begin n_fail++; $display("FAIL set_wins_count got=%0d exp=2", count[2]); end
   endtask

   task automatic test_saturation();
      raw = 8'h00;
      for (int k = 0; k < 17; k++) begin
         raw[5] = 1'b1; repeat (4) tick();
         raw[5] = 1'b0; en[5] = 1'b0; tick();
         en[5] = 1'b1;
      end
      n_checks++; if (count[5] !== 4'd15) begin n_fail++; $display("FAIL sat_count got=%0d exp=15", count[5]); end
      raw[5] = 1'b1; repeat (3) tick();
      fclr[5] = 1'b1; tick();
      n_checks++; if (count[5] !== 4'd1) begin n_fail++; $display("FAIL fclr_event got=%0d exp=1", count[5]); end
      raw[5] = 1'b0; fclr[5] = 1'b1; tick();
      n_checks++; if (count[5] !== 4'd0) begin n_fail++; $display("FAIL fclr_only got=%0d exp=0", count[5]); end
   endtask

   task automatic test_enable_reset();
      raw = 8'h02; en = 8'hFD;
      repeat (100) tick();
      n_checks++; if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL en_irq got=%b exp=0", irq[1]); end
      n_checks++; if (count[1] !== 4'd0) begin n_fail++; $display("FAIL en_count got=%0d exp=0", count[1]); end
      n_checks++; if (active[1] !== 1'b0) begin n_fail++; $display("FAIL en_active got=%b exp=0", active[1]); end
      raw = 8'h00; en = 8'h00; tick();
      en = 8'hFF; raw = 8'hFF; repeat (2) tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (irq !== '0) begin n_fail++; $display("FAIL arst_irq got=%b exp=0", irq); end
      n_checks++; if (count !== '0) begin n_fail++; $display("FAIL arst_count got=%h exp=0", count); end
      n_checks++; if (active !== '0) begin n_fail++; $display("FAIL arst_active got=%b exp=0", active); end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      n_checks++; if (irq !== '0) begin n_fail++; $display("FAIL requal_early got=%b exp=0", irq); end
      tick();
      n_checks++; if (irq !== 8'hFF) begin n_fail++; $display("FAIL requal_irq got=%b exp=11111111", irq); end
      for (int c = 0; c < N_CH; c++) begin
         n_checks++; if (count[c] !== 4'd1) begin n_fail++; $display("FAIL requal_count ch=%0d got=%0d exp=1", c, count[c]); end
      end
   endtask

   task automatic test_independence();
      raw = 8'h00; en = 8'h00; clr = 8'hFF; fclr = 8'hFF; tick();
      en = 8'hFF; raw = 8'h81;
      repeat (4) tick();
      n_checks++; if (irq !== 8'h81) begin n_fail++; $display("FAIL indep_irq got=%b exp=10000001", irq); end
      n_checks++; if (irq_any !== 1'b1) begin n_fail++; $display("FAIL indep_any got=%b exp=1", irq_any); end
      n_checks++; if (active !== 8'h81) begin n_fail++; $display("FAIL indep_active got=%b exp=10000001", active); end
      for (int c = 0; c < N_CH; c++) begin
         n_checks++;
         if (count[c] !== ((c == 0 || c == 7) ? 4'd1 : 4'd0)) begin
            n_fail++; $display("FAIL indep_count ch=%0d got=%0d", c, count[c]);
         end
      end
   endtask

   task automatic test_random();
      raw = 8'h00;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int c = 0; c < N_CH; c++) begin
            if (raw[c]) raw[c] = ($urandom_range(0, 5) != 0);
            else        raw[c] = ($urandom_range(0, 11) == 0);
            en[c]   = ($urandom_range(0, 59) != 0);
            clr[c]  = ($urandom_range(0, 19) == 0);
            fclr[c] = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0) mask[c] = ~mask[c];
         end
         tick();
         n_checks++; if (irq !== model_irq()) begin n_fail++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", cyc, irq, model_irq()); end
         n_checks++; if (irq_any !== (|model_irq())) begin n_fail++; $display("FAIL rnd_any cyc=%0d got=%b", cyc, irq_any); end
         n_checks++; if (active !== model_active()) begin n_fail++; $display("FAIL rnd_active cyc=%0d got=%b exp=%b", cyc, active, model_active()); end
         for (int c = 0; c < N_CH; c++) begin
            n_checks++;
            if (count[c] !== cnt[c][CNT_W-1:0]) begin
               n_fail++; $display("FAIL rnd_count cyc=%0d ch=%0d got=%0d exp=%0d", cyc, c, count[c], cnt[c]);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      raw = '0; en = '1; mask = '0; clr = '0; fclr = '0;
      model_reset();
      test_reset();
      test_qualify();
      test_holdoff();
      test_mask_clear();
      test_saturation();
      test_enable_reset();
      test_independence();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
